// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer around the program counter.
// Holds the PC, issues one instruction-memory request at a time, and hands each
// fetched word to decode over a valid/ready handshake. Supports redirects with
// squash of an in-flight fetch, halt/resume, and sticky misaligned-target flag.
//
// Ports:
//   clk, reset          clock (posedge), asynchronous active-low reset
//   imem_req/addr       fetch request and address (addr == pc while req)
//   imem_ack/rdata      memory response for the current request
//   inst_valid/pc/data  instruction presented to decode
//   inst_ready          decode accepts (transfer = inst_valid & inst_ready)
//   redirect_valid/target  one-cycle redirect pulse and new PC
//   halt                level; stop at the next instruction boundary
//   halted              sequencer sits in HALTED
//   misaligned          sticky; some redirect target had addr[1:0] != 0
//   pc                  next address to fetch
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [INST_W-1:0] inst_data,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted,
    output logic              misaligned,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, inst_pc_nxt;
    logic [INST_W-1:0] inst_data_nxt;
    logic              misaligned_nxt;
    // squash marks that the outstanding request belongs to a stale stream;
    // pend_target is where to go once that request finally acks.
    logic              squash, squash_nxt;
    logic [ADDR_W-1:0] pend_target, pend_target_nxt;
    logic              redir_bad;

    assign redir_bad  = redirect_target[1:0] != 2'b00;

    assign imem_req   = (state == REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);
    assign halted     = (state == HALTED);

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inst_pc_nxt     = inst_pc;
        inst_data_nxt   = inst_data;
        misaligned_nxt  = misaligned;
        squash_nxt      = squash;
        pend_target_nxt = pend_target;

        if (redirect_valid && redir_bad) begin
            // Bad target: park in HALTED with pc untouched; only a later
            // aligned redirect restarts fetch.
            misaligned_nxt = 1'b1;
            squash_nxt     = 1'b0;
            state_nxt      = HALTED;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_nxt    = redirect_target;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = halt ? HALTED : REQ;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            // Response this cycle is dropped; restart at target.
                            pc_nxt     = redirect_target;
                            squash_nxt = 1'b0;
                        end else begin
                            // Request stays on the bus; remember target (last wins).
                            pend_target_nxt = redirect_target;
                            squash_nxt      = 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (squash) begin
                            pc_nxt     = pend_target;
                            squash_nxt = 1'b0;
                        end else begin
                            inst_data_nxt = imem_rdata;
                            inst_pc_nxt   = pc;
                            pc_nxt        = pc + STEP;
                            state_nxt     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_nxt    = redirect_target;
                        state_nxt = REQ;
                    end else if (inst_ready) begin
                        state_nxt = halt ? HALTED : REQ;
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc_nxt    = redirect_target;
                        state_nxt = REQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst_pc     <= '0;
            inst_data   <= '0;
            misaligned  <= 1'b0;
            squash      <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst_pc     <= inst_pc_nxt;
            inst_data   <= inst_data_nxt;
            misaligned  <= misaligned_nxt;
            squash      <= squash_nxt;
            pend_target <= pend_target_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc, inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt, halted, misaligned;
    logic [31:0] pc;

    // second instance: wrap-around reset PC, zero-wait memory, always ready
    logic        w_req, w_valid, w_halted, w_mis;
    logic [31:0] w_addr, w_ipc, w_idata, w_pc;

    int total = 0;
    int bad   = 0;

    // memory model: ack after mem_lat (or random rl) wait cycles; data = addr ^ key
    logic        rand_lat = 1'b0;
    int          mem_lat  = 0;
    logic [31:0] key      = 32'h0;
    logic [1:0]  rl;
    int          cnt;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (cnt >= (rand_lat ? int'(rl) : mem_lat));
    assign imem_rdata = imem_addr ^ key;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 0;
            rl  <= 2'd0;
        end else if (!imem_req || imem_ack) begin
            cnt <= 0;
            if (imem_ack) rl <= 2'($urandom_range(0, 3));
        end else begin
            cnt <= cnt + 1;
        end
    end

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .halted(halted), .misaligned(misaligned), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_addr),
        .inst_valid(w_valid), .inst_pc(w_ipc), .inst_data(w_idata),
        .inst_ready(1'b1),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .halt(1'b0), .halted(w_halted), .misaligned(w_mis), .pc(w_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        inst_ready      = 1'b0;
        rand_lat        = 1'b0;
        mem_lat         = 0;
        key             = 32'h0;
        reset           = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        inst_ready = 1'b1;
        repeat (7) tick();
        #2 reset = 1'b0;  // asynchronous assertion mid-cycle
        #1;
        total++; if (pc !== 32'h0)         begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (inst_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        total++; if (inst_pc !== 32'h0)    begin bad++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        total++; if (inst_data !== 32'h0)  begin bad++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
        total++; if (halted !== 1'b0)      begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (misaligned !== 1'b0)  begin bad++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
        tick();
        reset = 1'b1;
        total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_stream_and_hold();
        logic [31:0] addrs[$];
        int          dcyc[$];
        int          k = 0;
        logic        found = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (imem_req) addrs.push_back(imem_addr);
            if (inst_valid) begin
                dcyc.push_back(c);
                total++; if (inst_pc !== 32'(4 * k) || inst_data !== inst_pc) begin
                    bad++; $display("FAIL stream_inst: got pc=%h data=%h want %h", inst_pc, inst_data, 4 * k);
                end
                k++;
                if (inst_pc == 32'h8) begin found = 1'b1; inst_ready = 1'b0; break; end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL stream_timeout: got no delivery at 8 want one"); end
        total++; if (addrs.size() != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            bad++; $display("FAIL stream_addrs: got %0d addresses want 0,4,8", addrs.size());
        end
        total++; if (dcyc.size() != 3 || dcyc[1] - dcyc[0] != 2 || dcyc[2] - dcyc[1] != 2) begin
            bad++; $display("FAIL stream_rate: got %0d deliveries/unequal spacing want every 2 cycles", dcyc.size());
        end
        repeat (5) begin
            tick();
            total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h8 || imem_req !== 1'b0 || pc !== 32'hC) begin
                bad++; $display("FAIL hold_stable: got v=%b pc=%h data=%h req=%b npc=%h want 1/8/8/0/c",
                                inst_valid, inst_pc, inst_data, imem_req, pc);
            end
        end
        inst_ready = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            bad++; $display("FAIL stream_fourth: got req=%b addr=%h want 1/c", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        mem_lat    = 3;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (imem_req && imem_addr == 32'h8) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rw_timeout: got no fetch at 8 want one"); end
        tick();  // second wait cycle
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || imem_ack !== 1'b0) begin
            bad++; $display("FAIL rw_held1: got req=%b addr=%h ack=%b want 1/8/0", imem_req, imem_addr, imem_ack);
        end
        tick();
        total++; if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin
            bad++; $display("FAIL rw_held2: got addr=%h ack=%b want 8/1", imem_addr, imem_ack);
        end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rw_newaddr: got req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, inst_valid);
        end
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inst_valid) begin found = 1'b1; break; end
        end
        total++; if (!found || inst_pc !== 32'h100 || inst_data !== 32'h100) begin
            bad++; $display("FAIL rw_deliver: got v=%b pc=%h data=%h want 1/100/100", found, inst_pc, inst_data);
        end
    endtask

    task automatic test_redirect_hold();
        logic found = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inst_valid) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rh_timeout: got no delivery want one"); end
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL rh_drop: got v=%b req=%b addr=%h want 0/1/40", inst_valid, imem_req, imem_addr);
        end
        tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h40) begin
            bad++; $display("FAIL rh_next: got v=%b pc=%h data=%h want 1/40/40", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_halt_misaligned();
        logic found = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        mem_lat    = 2;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (imem_req && imem_addr == 32'h10) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL halt_timeout: got no fetch at 10 want one"); end
        halt  = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inst_valid) begin found = 1'b1; break; end
        end
        total++; if (!found || inst_pc !== 32'h10) begin
            bad++; $display("FAIL halt_deliver: got v=%b pc=%h want 1/10", found, inst_pc);
        end
        repeat (3) begin
            tick();
            total++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                bad++; $display("FAIL halt_state: got halted=%b req=%b v=%b want 1/0/0", halted, imem_req, inst_valid);
            end
        end
        halt            = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL resume: got halted=%b req=%b addr=%h want 0/1/200", halted, imem_req, imem_addr);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0;
        repeat (3) begin
            total++; if (misaligned !== 1'b1 || halted !== 1'b1 || pc !== 32'h200 || imem_req !== 1'b0) begin
                bad++; $display("FAIL misaligned: got mis=%b halted=%b pc=%h req=%b want 1/1/200/0",
                                misaligned, halted, pc, imem_req);
            end
            tick();
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick();
        redirect_valid = 1'b0;
        total++; if (misaligned !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'h300) begin
            bad++; $display("FAIL mis_sticky: got mis=%b halted=%b addr=%h want 1/0/300", misaligned, halted, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        total++; if (w_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_reset_pc: got %h want fffffffc", w_pc); end
        tick();
        total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
        tick();
        total++; if (w_ipc !== 32'hFFFF_FFFC || w_pc !== 32'h0 || w_mis !== 1'b0) begin
            bad++; $display("FAIL wrap_pc: got ipc=%h pc=%h mis=%b want fffffffc/0/0", w_ipc, w_pc, w_mis);
        end
        tick();
        total++; if (w_req !== 1'b1 || w_addr !== 32'h0 || w_halted !== 1'b0) begin
            bad++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", w_req, w_addr);
        end
    endtask

    // Model: the delivered stream is sequential from the last redirect target;
    // a redirect flushes anything not yet handed over, and a request that was
    // already outstanding when it arrived returns data that is never delivered.
    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] exp_fetch = 32'h0;
        logic [31:0] tgt;
        logic        redir;
        logic        discarding = 1'b0;
        int          delivered = 0;
        do_reset();
        rand_lat = 1'b1;
        key      = 32'h5A5A_0000;
        for (int c = 0; c < 800; c++) begin
            tick();
            redir           = ($urandom_range(0, 19) == 0);
            tgt             = 32'($urandom_range(0, 1023)) << 2;
            inst_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid  = redir;
            redirect_target = tgt;
            if (inst_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious: got valid pc=%h want no instruction", inst_pc);
                end else if (inst_pc !== exp_q[0] || inst_data !== (exp_q[0] ^ key)) begin
                    bad++; $display("FAIL rnd_inst: got pc=%h data=%h want %h/%h", inst_pc, inst_data, exp_q[0], exp_q[0] ^ key);
                end
                if (!redir && inst_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
            if (imem_req && imem_ack && !redir) begin
                if (discarding) begin
                    discarding = 1'b0;
                end else begin
                    total++; if (imem_addr !== exp_fetch) begin
                        bad++; $display("FAIL rnd_addr: got %h want %h", imem_addr, exp_fetch);
                    end
                    exp_q.push_back(exp_fetch);
                    exp_fetch += 32'd4;
                end
            end
            if (redir) begin
                exp_q.delete();
                exp_fetch  = tgt;
                discarding = imem_req && !imem_ack;
            end
        end
        redirect_valid = 1'b0;
        total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress: got %0d deliveries want >=50", delivered); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        inst_ready      = 1'b0;
        test_reset();
        test_stream_and_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_halt_misaligned();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch around the program counter: holds the current PC, issues one instruction-memory request at a time, and hands fetched words to decode over a valid/ready handshake.
- Applies redirects (jump/branch targets from execute) with squash of in-flight fetches, and supports halt/resume.
- Sits between the PC register, the instruction memory port and the decode stage.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has returned data for the current request; valid only when imem_req=1.
- imem_rdata  in  INST_W  fetched word; valid when imem_ack=1.
- inst_valid  out  1  fetched instruction available to decode.
- inst_pc  out  ADDR_W  address of the presented instruction.
- inst_data  out  INST_W  presented instruction word.
- inst_ready  in  1  decode accepts the instruction; transfer when inst_valid & inst_ready.
- redirect_valid  in  1  one-cycle pulse: replace the fetch stream with redirect_target.
- redirect_target  in  ADDR_W  new PC.
- halt  in  1  level; stop fetching at the next instruction boundary.
- halted  out  1  sequencer is in HALTED.
- misaligned  out  1  sticky; a redirect target had addr[1:0] != 0.
- pc  out  ADDR_W  current PC (next address to fetch).

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; imem_req=0; inst_valid=0; inst_pc=0; inst_data=0; halted=0; misaligned=0.
  - squash flag cleared; state=IDLE.
- States: IDLE, REQ, HOLD, HALTED.
  - imem_req=1 only in REQ.
  - inst_valid=1 only in HOLD.
  - halted=1 only in HALTED.
- IDLE: exactly one cycle after reset release, then REQ; goes to HALTED instead if halt=1.
- REQ:
  - imem_addr=pc, held stable until imem_ack.
  - Ack may arrive in the same cycle as the request or any later cycle.
  - On ack with squash=0: inst_data<=imem_rdata, inst_pc<=pc, pc<=pc+PC_STEP, go to HOLD.
- HOLD:
  - inst_pc/inst_data held stable.
  - On transfer: go to HALTED if halt=1, else REQ.
- HALTED: no requests issued; leaves only on redirect.
- Minimum fetch latency: with zero-wait memory (ack in the same cycle as the request) and inst_ready=1, one instruction is delivered every 2 cycles.
- PC arithmetic: modulo 2^ADDR_W. pc at max value + PC_STEP wraps to the low value; no error is flagged.
- Redirect (has priority over halt and normal progress in the same cycle):
  - Misaligned target (redirect_target[1:0] != 0): misaligned<=1, state<=HALTED, pc unchanged, no further fetch.
  - REQ, no ack this cycle: pending target latched, squash<=1, stay in REQ with imem_addr unchanged (an in-flight request is never cancelled).
  - REQ, ack this cycle: returned data discarded, pc<=target, stay in REQ. The new address appears next cycle.
  - REQ with squash=1 when ack arrives: data discarded, pc<=latched target, squash<=0, stay in REQ. A second redirect before the ack overwrites the latched target (last wins).
  - HOLD: presented instruction dropped (inst_valid=0 next cycle, even if inst_ready=1 this cycle; no transfer counted), pc<=target, go to REQ.
  - IDLE or HALTED: pc<=target, go to REQ; misaligned stays at its current value.
- Halt raised while in REQ: the fetch completes and is delivered; the transfer in HOLD then moves to HALTED.
- Reset asserted mid-fetch: everything returns to reset values immediately. A memory ack for the abandoned request arriving after reset release is ignored, because IDLE holds imem_req=0.

Test Plan:
- Reset release, zero-wait memory returning {addr}, inst_ready=1 -> imem_addr sequence 0,4,8,12; inst_pc 0,4,8 with inst_data equal to inst_pc; one delivery every 2 cycles.
- inst_ready=0 for 5 cycles in HOLD at pc 8 -> inst_pc=8 and inst_data stable, imem_req=0 throughout; pc=0xC.
- Memory with 3-cycle ack; redirect_valid=1 with target 0x100 during the second wait cycle of fetch at 0x8 -> imem_addr held at 0x8 until ack; that data not delivered; next imem_addr=0x100.
- Redirect to 0x40 in HOLD with inst_ready=1 in the same cycle -> no transfer counted; next fetch address 0x40, next inst_pc=0x40.
- halt=1 during fetch at 0x10 -> 0x10 delivered, then halted=1 and no requests; redirect to 0x200 -> halted=0, fetch at 0x200.
- Redirect to 0x102 -> misaligned=1, halted=1, pc unchanged. pc=RESET_PC=0xFFFFFFFC -> next fetch at 0x0.
